// File: rtl/lb_arb2.sv
// Two-master local-bus arbiter: captures one request per master and
// serializes them round-robin onto a single shared bus.
module lb_arb2 #(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 32,
   parameter int READ_DELAY = 3
) (
   input  logic              lb_clk,
   input  logic              rst_n,
   input  logic              m0_strobe,
   input  logic              m0_rd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_busy,
   output logic              m0_drop,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_strobe,
   input  logic              m1_rd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_busy,
   output logic              m1_drop,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              lb_strobe,
   output logic              lb_rd,
   output logic [ADDR_W-1:0] lb_addr,
   output logic [DATA_W-1:0] lb_dout,
   input  logic [DATA_W-1:0] lb_din
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            st, st_n;
   logic              rst_i;
   logic              gnt, gnt_n, last;
   logic              ld, smp;
   logic [3:0]        cnt;
   logic [1:0]        stb, rdi, pend, drop, ack;
   logic [ADDR_W-1:0] addri [2];
   logic [DATA_W-1:0] wdati [2];
   logic [1:0]        rd_q;
   logic [ADDR_W-1:0] addr_q [2];
   logic [DATA_W-1:0] wdat_q [2];
   logic [DATA_W-1:0] rdat_q [2];
   logic              lb_rd_q;
   logic [ADDR_W-1:0] lb_addr_q;
   logic [DATA_W-1:0] lb_dout_q;

   // Release is retimed by one flop so the first capture lands on the
   // second edge after rst_n rises; assertion stays asynchronous.
   always_ff @(posedge lb_clk or negedge rst_n)
      if (!rst_n) rst_i <= 1'b0;
      else        rst_i <= 1'b1;

   assign stb      = {m1_strobe, m0_strobe};
   assign rdi      = {m1_rd, m0_rd};
   assign addri[0] = m0_addr;
   assign addri[1] = m1_addr;
   assign wdati[0] = m0_wdata;
   assign wdati[1] = m1_wdata;

   assign ack = {(st == DONE) & gnt, (st == DONE) & ~gnt};

   always_ff @(posedge lb_clk or negedge rst_i)
      if (!rst_i) begin
         pend <= '0;
         drop <= '0;
         rd_q <= '0;
         for (int i = 0; i < 2; i++) begin
            addr_q[i] <= '0;
            wdat_q[i] <= '0;
            rdat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            drop[i] <= stb[i] & pend[i] & ~ack[i];
            if (stb[i] && (!pend[i] || ack[i])) begin
               pend[i]   <= 1'b1;
               rd_q[i]   <= rdi[i];
               addr_q[i] <= addri[i];
               wdat_q[i] <= wdati[i];
            end else if (ack[i]) begin
               pend[i] <= 1'b0;
            end
            if (smp && gnt == 1'(i))
               rdat_q[i] <= lb_din;
         end
      end

   always_comb begin
      st_n  = st;
      gnt_n = gnt;
      ld    = 1'b0;
      smp   = 1'b0;
      unique case (st)
         IDLE:
            if (|pend) begin
               ld    = 1'b1;
               gnt_n = (&pend) ? ~last : pend[1];
               st_n  = ISSUE;
            end
         ISSUE: st_n = lb_rd_q ? WAIT : DONE;
         WAIT:
            if (cnt == 4'(READ_DELAY)) begin
               smp  = 1'b1;
               st_n = DONE;
            end
         DONE: st_n = IDLE;
      endcase
   end

   always_ff @(posedge lb_clk or negedge rst_i)
      if (!rst_i) begin
         st        <= IDLE;
         gnt       <= 1'b0;
         last      <= 1'b1;
         cnt       <= '0;
         lb_rd_q   <= 1'b0;
         lb_addr_q <= '0;
         lb_dout_q <= '0;
      end else begin
         st  <= st_n;
         gnt <= gnt_n;
         // ISSUE is count 0, so the first WAIT cycle is count 1
         if (st == ISSUE)     cnt <= 4'd1;
         else if (st == WAIT) cnt <= cnt + 4'd1;
         else                 cnt <= '0;
         if (ld) begin
            last      <= gnt_n;
            lb_rd_q   <= rd_q[gnt_n];
            lb_addr_q <= addr_q[gnt_n];
            lb_dout_q <= wdat_q[gnt_n];
         end
      end

   assign lb_strobe = (st == ISSUE);
   assign lb_rd     = lb_rd_q;
   assign lb_addr   = lb_addr_q;
   assign lb_dout   = lb_dout_q;
   assign m0_busy   = pend[0];
   assign m1_busy   = pend[1];
   assign m0_drop   = drop[0];
   assign m1_drop   = drop[1];
   assign m0_ack    = ack[0];
   assign m1_ack    = ack[1];
   assign m0_rdata  = rdat_q[0];
   assign m1_rdata  = rdat_q[1];

endmodule

// File: tb/tb_lb_arb2.sv
// Randomized bench for lb_arb2 against a timestamp-based transaction model.
module tb_lb_arb2;

   localparam int AW = 24;
   localparam int DW = 32;
   localparam int RD = 3;

   logic          lb_clk = 1'b0;
   logic          rst_n  = 1'b0;
   logic          m0_strobe = 0, m0_rd = 0, m1_strobe = 0, m1_rd = 0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, lb_din = '0;
   logic          m0_busy, m0_drop, m0_ack, m1_busy, m1_drop, m1_ack;
   logic [DW-1:0] m0_rdata, m1_rdata, lb_dout;
   logic          lb_strobe, lb_rd;
   logic [AW-1:0] lb_addr;

   always #5 lb_clk = ~lb_clk;

   lb_arb2 #(.ADDR_W(AW), .DATA_W(DW), .READ_DELAY(RD)) dut (
      .lb_clk(lb_clk), .rst_n(rst_n),
      .m0_strobe(m0_strobe), .m0_rd(m0_rd), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_busy(m0_busy), .m0_drop(m0_drop),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_strobe(m1_strobe), .m1_rd(m1_rd), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_busy(m1_busy), .m1_drop(m1_drop),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .lb_strobe(lb_strobe), .lb_rd(lb_rd), .lb_addr(lb_addr),
      .lb_dout(lb_dout), .lb_din(lb_din)
   );

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int n_ack0 = 0, n_drop0 = 0, n_stb = 0;
   bit din_rand = 1;

   // Reference model: requests per master, one bus job with timestamps
   bit          msync;
   bit          pend [2];
   bit          p_rd [2];
   logic [AW-1:0] p_addr [2];
   logic [DW-1:0] p_wd [2];
   bit          drop_q [2];
   logic [DW-1:0] rdat [2];
   bit          bus_act, g_rd;
   int          gnt, last, t_iss, t_smp, t_ack;
   logic          e_rd;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_dout;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
      end
   endtask

   function automatic bit m_ack(int n);
      return msync && bus_act && cyc == t_ack && gnt == n;
   endfunction

   task automatic model_reset();
      msync = 0; bus_act = 0; g_rd = 0;
      gnt = 0; last = 1; t_iss = -1; t_smp = -1; t_ack = -1;
      e_rd = 0; e_addr = '0; e_dout = '0;
      for (int n = 0; n < 2; n++) begin
         pend[n] = 0; p_rd[n] = 0; p_addr[n] = '0; p_wd[n] = '0;
         drop_q[n] = 0; rdat[n] = '0;
      end
   endtask

   task automatic model_update();
      bit          a [2];
      bit          s [2];
      bit          r [2];
      logic [AW-1:0] ad [2];
      logic [DW-1:0] wd [2];
      int          g;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (!msync) begin
         msync = 1;
         return;
      end
      s[0] = m0_strobe; r[0] = m0_rd; ad[0] = m0_addr; wd[0] = m0_wdata;
      s[1] = m1_strobe; r[1] = m1_rd; ad[1] = m1_addr; wd[1] = m1_wdata;
      a[0] = m_ack(0);
      a[1] = m_ack(1);
      if (bus_act && g_rd && cyc == t_smp) rdat[gnt] = lb_din;
      if (!bus_act && (pend[0] || pend[1])) begin
         if (pend[0] && pend[1]) g = 1 - last;
         else                    g = pend[0] ? 0 : 1;
         bus_act = 1; gnt = g; last = g; g_rd = p_rd[g];
         e_rd = p_rd[g]; e_addr = p_addr[g]; e_dout = p_wd[g];
         t_iss = cyc + 1;
         t_smp = cyc + 1 + RD;
         t_ack = g_rd ? cyc + 2 + RD : cyc + 2;
      end else if (bus_act && cyc == t_ack) begin
         bus_act = 0;
      end
      for (int n = 0; n < 2; n++) begin
         drop_q[n] = 0;
         if (s[n] && (!pend[n] || a[n])) begin
            pend[n] = 1; p_rd[n] = r[n]; p_addr[n] = ad[n]; p_wd[n] = wd[n];
         end else begin
            if (s[n]) drop_q[n] = 1;
            if (a[n]) pend[n] = 0;
         end
      end
   endtask

   task automatic compare();
      check("lb_strobe", lb_strobe, msync && bus_act && cyc == t_iss);
      check("lb_rd", lb_rd, e_rd);
      check("lb_addr", lb_addr, e_addr);
      check("lb_dout", lb_dout, e_dout);
      check("m0_ack", m0_ack, m_ack(0));
      check("m1_ack", m1_ack, m_ack(1));
      check("m0_busy", m0_busy, pend[0]);
      check("m1_busy", m1_busy, pend[1]);
      check("m0_drop", m0_drop, drop_q[0]);
      check("m1_drop", m1_drop, drop_q[1]);
      check("m0_rdata", m0_rdata, rdat[0]);
      check("m1_rdata", m1_rdata, rdat[1]);
      n_ack0  += int'(m0_ack);
      n_drop0 += int'(m0_drop);
      n_stb   += int'(lb_strobe);
   endtask

   task automatic step();
      @(negedge lb_clk);
      compare();
      @(posedge lb_clk);
      model_update();
      cyc++;
      #1;
      if (din_rand) lb_din = $urandom;
   endtask

   task automatic idle_in();
      m0_strobe = 0;
      m1_strobe = 0;
   endtask

   task automatic req(int n, bit rd, logic [AW-1:0] ad, logic [DW-1:0] wd);
      if (n == 0) begin
         m0_strobe = 1; m0_rd = rd; m0_addr = ad; m0_wdata = wd;
      end else begin
         m1_strobe = 1; m1_rd = rd; m1_addr = ad; m1_wdata = wd;
      end
   endtask

   task automatic do_reset(int n);
      rst_n = 0;
      model_reset();
      idle_in();
      repeat (n) step();
      rst_n = 1;
   endtask

   task automatic rand_in(int pct);
      m0_strobe = ($urandom_range(99) < pct);
      m1_strobe = ($urandom_range(99) < pct);
      m0_rd = $urandom_range(1); m1_rd = $urandom_range(1);
      m0_addr = AW'($urandom); m1_addr = AW'($urandom);
      m0_wdata = $urandom; m1_wdata = $urandom;
   endtask

   int a0, d0, s0, k;

   initial begin
      model_reset();
      #1;
      do_reset(3);
      // release cycle strobe is too early; next one is captured
      req(0, 0, 24'h55, 32'h1);
      step();
      idle_in();
      req(1, 0, 24'h66, 32'h2);
      step();
      idle_in();
      repeat (6) step();

      // single write
      req(0, 0, 24'h000010, 32'hDEADBEEF);
      step();
      idle_in();
      repeat (5) step();
      check("wr_hold_dout", lb_dout, 32'hDEADBEEF);

      // single read with fixed bus data
      din_rand = 0;
      lb_din = 32'h12345678;
      req(1, 1, 24'h20, '0);
      step();
      idle_in();
      repeat (8) step();
      check("rd_data", m1_rdata, 32'h12345678);
      din_rand = 1;

      // contention after reset, then repeated
      do_reset(2);
      step();
      repeat (2) begin
         req(0, 0, 24'h100, 32'hA0);
         req(1, 0, 24'h200, 32'hB0);
         step();
         idle_in();
         repeat (10) step();
      end

      // overrun
      a0 = n_ack0; d0 = n_drop0; s0 = n_stb;
      req(0, 0, 24'h300, 32'hC0);
      step();
      req(0, 0, 24'h301, 32'hC1);
      step();
      idle_in();
      repeat (6) step();
      check("ovr_acks", n_ack0 - a0, 1);
      check("ovr_drops", n_drop0 - d0, 1);
      check("ovr_strobes", n_stb - s0, 1);

      // back-to-back writes from m0, each strobe in its ack cycle
      a0 = n_ack0; d0 = n_drop0;
      req(0, 0, 24'h400, 32'h0);
      step();
      idle_in();
      k = 1;
      for (int i = 0; i < 100 && n_ack0 - a0 < 10; i++) begin
         if (m_ack(0) && k < 10) begin
            req(0, 0, AW'(24'h400 + k), DW'(k));
            k++;
         end
         step();
         idle_in();
      end
      check("b2b_acks", n_ack0 - a0, 10);
      check("b2b_drops", n_drop0 - d0, 0);

      // reset during WAIT aborts, then a fresh read completes
      req(1, 1, 24'h500, '0);
      step();
      idle_in();
      repeat (4) step();
      rst_n = 0;
      model_reset();
      step();
      check("abort_busy", m1_busy, 0);
      check("abort_ack", m1_ack, 0);
      rst_n = 1;
      step();
      req(1, 1, 24'h501, '0);
      step();
      idle_in();
      repeat (8) step();

      // random traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(999) < 3) begin
            do_reset($urandom_range(2) + 1);
         end else begin
            rand_in(35);
         end
         step();
      end
      idle_in();
      repeat (12) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
